// File: rtl/seq_divider_if.sv
//==============================================================================
// Module      : seq_divider_if
// Description : Operand/launch and result bundle between control and divider.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, dividend, divisor,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, div_zero, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/seq_divider.sv
//==============================================================================
// Module      : seq_divider
// Description : Multicycle signed radix-2 restoring divider (MIPS DIV HI/LO).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_divider #(
    parameter int WIDTH = 32
) (
    input  wire logic       clk,
    input  wire logic       reset,
    seq_divider_if.slave    bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvsr;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;

    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;

    // Magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude.
    assign w_dvd_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign w_dvs_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

    // r_quo starts as the dividend magnitude; its MSB shifts into the
    // remainder while quotient bits fill in from the LSB.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dvsr};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvsr     <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_cnt      <= '0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            r_div_zero <= 1'b1;
                            r_done     <= 1'b1;
                            r_state    <= DONE;
                        end else begin
                            r_div_zero <= 1'b0;
                            r_quo      <= w_dvd_mag;
                            r_dvsr     <= w_dvs_mag;
                            r_sign_q   <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                            r_sign_r   <= bus.dividend[WIDTH-1];
                            r_rem      <= '0;
                            r_cnt      <= CNT_W'(WIDTH);
                            r_busy     <= 1'b1;
                            r_state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    // Negative trial difference means restore the shifted value.
                    r_rem <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    r_lo    <= r_sign_q ? -r_quo : r_quo;
                    r_hi    <= r_sign_r ? -r_rem : r_rem;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.div_zero = r_div_zero;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
//==============================================================================
// Module      : tb_seq_divider
// Description : Scoreboard bench for seq_divider against a signed-arithmetic model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_seq_divider;
    localparam int WIDTH = 32;
    localparam int LAT   = WIDTH + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_divider_if #(.WIDTH(WIDTH)) dif ();

    seq_divider #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain signed division at 64 bits, so the INT_MIN/-1 case
    // wraps naturally when truncated back to 32 bits.
    task automatic model(input logic [31:0] a, input logic [31:0] b, output exp_t e);
        longint sa;
        longint sd;
        longint q;
        longint r;
        if (b == 32'd0) begin
            e.hi = m_hi;
            e.lo = m_lo;
            e.dz = 1'b1;
        end else begin
            sa = $signed(a);
            sd = $signed(b);
            q  = sa / sd;
            r  = sa % sd;
            m_lo = q[31:0];
            m_hi = r[31:0];
            e.hi = m_hi;
            e.lo = m_lo;
            e.dz = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((dif.busy || dif.done) && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (k >= 60) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: busy=%b done=%b", dif.busy, dif.done);
        end
    endtask

    // Issue one launch; returns at the negedge right after the start edge.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        wait_idle();
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
        model(a, b, e);
        e.cyc = cyc + 1 + ((b == 32'd0) ? 0 : LAT);
        sb.push_back(e);
        @(negedge clk);
        dif.start = 1'b0;
        check("div_zero_after_start", {31'b0, dif.div_zero}, {31'b0, (b == 32'd0)});
        check("busy_after_start", {31'b0, dif.busy}, {31'b0, (b != 32'd0)});
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && dif.done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check("lo", dif.lo, e.lo);
                check("hi", dif.hi, e.hi);
                check("div_zero", {31'b0, dif.div_zero}, {31'b0, e.dz});
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int nb;
        logic [31:0] a;
        logic [31:0] b;
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;

        #12;
        check("rst_hi", dif.hi, 32'd0);
        check("rst_lo", dif.lo, 32'd0);
        check("rst_busy", {31'b0, dif.busy}, 32'd0);
        check("rst_done", {31'b0, dif.done}, 32'd0);
        check("rst_div_zero", {31'b0, dif.div_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Basic case with busy-window length
        do_div(32'd100, 32'd7);
        nb = dif.busy ? 1 : 0;
        for (int i = 0; i < 39; i++) begin
            @(negedge clk);
            if (dif.busy) nb++;
        end
        check("busy_cycles", nb, 32'd33);

        // Sign combinations
        do_div(-32'sd7, 32'd2);
        do_div(32'd7, -32'sd2);
        do_div(-32'sd7, -32'sd2);

        // Divide-by-zero keeps the previous result, then clears on next start
        do_div(32'd100, 32'd7);
        do_div(32'd5, 32'd0);
        do_div(32'd9, 32'd3);

        // Boundary values
        do_div(32'h8000_0000, 32'hFFFF_FFFF);
        do_div(32'd0, 32'd5);
        do_div(32'd5, 32'd9);

        // Asynchronous reset in the middle of a run
        do_div(32'd100, 32'd7);
        repeat (8) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_hi", dif.hi, 32'd0);
        check("midrst_lo", dif.lo, 32'd0);
        check("midrst_busy", {31'b0, dif.busy}, 32'd0);
        check("midrst_done", {31'b0, dif.done}, 32'd0);
        void'(sb.pop_back());
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        do_div(32'd100, 32'd7);

        // Restart attempt and operand changes while busy are ignored
        do_div(32'd1000, -32'sd13);
        repeat (4) @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = 32'd77;
        dif.divisor  = 32'd0;
        @(negedge clk);
        dif.start    = 1'b0;
        dif.dividend = 32'd5;
        dif.divisor  = 32'd1;
        wait_idle();

        // Randomized operands, including zero and small divisors
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1, 2:    b = ($urandom_range(0, 1) != 0) ? -32'($urandom_range(1, 20))
                                                          : 32'($urandom_range(1, 20));
                3:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 4) == 0) a = 32'($urandom_range(0, 50));
            do_div(a, b);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

`default_nettype wire
